// File: rtl/fpga_cfg_loader_pkg.sv
// fpga_cfg_pkg: shared constants, state enum and word type for the
// configuration loader (fpga_cfg_loader and cfg_frame_asm).
package fpga_cfg_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [5:0] END_ADDR    = 6'h3F;
  localparam logic [5:0] NUM_TARGETS = 6'd43;

  localparam logic [5:0] A_BASE  = 6'd0;
  localparam logic [5:0] L1_ADDR = 6'd24;
  localparam logic [5:0] B_BASE  = 6'd25;
  localparam logic [5:0] C_BASE  = 6'd33;
  localparam logic [5:0] E1_ADDR = 6'd41;
  localparam logic [5:0] D1_ADDR = 6'd42;

  typedef logic [32:0] cfg_word_t;

  typedef enum logic [2:0] {
    S_HUNT,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/fpga_cfg_loader_frame_asm.sv
// cfg_frame_asm: data-byte counter, MSB-first word shifter and XOR
// accumulator. Ports: clr_i starts a frame, shift_i takes byte_i;
// last_o flags the 4th data byte, word_o is the word so far.
// xsum_o / addr_i exist only when CFG_CHECKSUM_EN is defined.
module cfg_frame_asm
  import fpga_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
`ifdef CFG_CHECKSUM_EN
  input  logic [7:0]  addr_i,
  output logic [7:0]  xsum_o,
`endif
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic        last_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clr_i) begin
      cnt_d  = 2'd0;
      word_d = '0;
    end else if (shift_i) begin
      cnt_d  = cnt_q + 2'd1;
      word_d = {word_q[23:0], byte_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

`ifdef CFG_CHECKSUM_EN
  // Seeded with the full ADDR byte, mode and ignored bit included.
  logic [7:0] xsum_q, xsum_d;

  always_comb begin
    xsum_d = xsum_q;
    if (clr_i)        xsum_d = addr_i;
    else if (shift_i) xsum_d = xsum_q ^ byte_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) xsum_q <= '0;
    else     xsum_q <= xsum_d;
  end

  assign xsum_o = xsum_q;
`endif

  assign last_o = (cnt_q == 2'd3);
  assign word_o = word_q;

endmodule

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: parses SYNC/ADDR/D3..D0[/CHK] byte frames and issues
// one 33-bit write per frame to fabric config storage. Ports: cfg_valid/
// cfg_data/cfg_ready byte stream in; wr_en/wr_addr/wr_data write out;
// frame_count, sticky cfg_done / cfg_error. Macro: CFG_CHECKSUM_EN.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  input  logic [7:0]  cfg_data,
  output logic        cfg_ready,
  output logic        wr_en,
  output logic [5:0]  wr_addr,
  output logic [32:0] wr_data,
  output logic [5:0]  frame_count,
  output logic        cfg_done,
  output logic        cfg_error
);

  state_e    state_q, state_d;
  logic [5:0] addr_q, addr_d;
  logic      mode_q, mode_d;
  logic      wr_en_q, wr_en_d;
  logic [5:0] wr_addr_q, wr_addr_d;
  cfg_word_t wr_data_q, wr_data_d;
  logic [5:0] fc_q, fc_d;
  logic      ready_q, ready_d;
  logic      done_q, done_d;
  logic      err_q, err_d;

  logic        acc, clr, shift, last;
  logic [31:0] word;

  assign acc = cfg_valid & ready_q;

`ifdef CFG_CHECKSUM_EN
  logic [7:0] xsum;
`else
  logic [7:0] unused_word_hi;
  assign unused_word_hi = word[31:24];
`endif

  cfg_frame_asm u_asm (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
`ifdef CFG_CHECKSUM_EN
    .addr_i  (cfg_data),
    .xsum_o  (xsum),
`endif
    .shift_i (shift),
    .byte_i  (cfg_data),
    .last_o  (last),
    .word_o  (word)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    fc_d      = fc_q;
    clr       = 1'b0;
    shift     = 1'b0;
    unique case (state_q)
      S_HUNT: begin
        if (acc && cfg_data == SYNC_BYTE) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (acc) begin
          if (cfg_data[5:0] == END_ADDR) begin
            state_d = S_DONE;
          end else if (cfg_data[5:0] >= NUM_TARGETS) begin
            state_d = S_ERR;
          end else begin
            addr_d  = cfg_data[5:0];
            mode_d  = cfg_data[7];
            clr     = 1'b1;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (acc) begin
          shift = 1'b1;
          if (last) begin
`ifdef CFG_CHECKSUM_EN
            state_d = S_CHK;
`else
            // Last byte is still on the bus; splice it in directly.
            state_d   = S_WRITE;
            wr_addr_d = addr_q;
            wr_data_d = {mode_q, word[23:0], cfg_data};
`endif
          end
        end
      end
      S_CHK: begin
`ifdef CFG_CHECKSUM_EN
        if (acc) begin
          if (cfg_data == xsum) begin
            state_d   = S_WRITE;
            wr_addr_d = addr_q;
            wr_data_d = {mode_q, word};
          end else begin
            state_d = S_ERR;
          end
        end
`else
        state_d = S_HUNT;
`endif
      end
      S_WRITE: begin
        state_d = S_HUNT;
      end
      S_DONE: state_d = S_DONE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_HUNT;
    endcase
    wr_en_d = (state_d == S_WRITE);
    if (wr_en_d && fc_q != 6'h3F) fc_d = fc_q + 6'd1;
    ready_d = (state_d == S_HUNT) || (state_d == S_ADDR) ||
              (state_d == S_DATA) || (state_d == S_CHK);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_HUNT;
      addr_q    <= '0;
      mode_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      fc_q      <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      mode_q    <= mode_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      fc_q      <= fc_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign cfg_ready   = ready_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_count = fc_q;
  assign cfg_done    = done_q;
  assign cfg_error   = err_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb_fpga_cfg_loader: directed frames with a write scoreboard.
// Adapts frame layout to CFG_CHECKSUM_EN.
module tb_fpga_cfg_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_data = '0;
  logic        cfg_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [32:0] wr_data;
  logic [5:0]  frame_count;
  logic        cfg_done;
  logic        cfg_error;

  int total = 0;
  int bad   = 0;

  logic [38:0] exp_q[$];

  always #5 clk = ~clk;

  fpga_cfg_loader dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_data    (cfg_data),
    .cfg_ready   (cfg_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_count (frame_count),
    .cfg_done    (cfg_done),
    .cfg_error   (cfg_error)
  );

  // Monitor: every write strobe must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got addr=%0d data=%h want none",
                 wr_addr, wr_data);
      end else begin
        logic [38:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          bad++;
          $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                   wr_addr, wr_data, e[38:33], e[32:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    cfg_valid = 1'b0;
    cyc(1);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    bit   ok;
    ok = 0;
    cfg_valid = 1'b0;
    if (gap > 0) cyc(gap);
    cfg_valid = 1'b1;
    cfg_data  = b;
    for (int n = 0; n < 16; n++) begin
      acc = cfg_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1;
        break;
      end
    end
    cfg_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout byte=%h got not_accepted want accepted", b);
    end
  endtask

  // Offers a byte for one cycle regardless of cfg_ready.
  task automatic poke(input logic [7:0] b);
    cfg_valid = 1'b1;
    cfg_data  = b;
    cyc(1);
    cfg_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] w,
                            input logic [7:0] chk, input int maxgap);
    send_byte(8'hA5, $urandom_range(0, maxgap));
    send_byte(a, $urandom_range(0, maxgap));
    send_byte(w[31:24], $urandom_range(0, maxgap));
    send_byte(w[23:16], $urandom_range(0, maxgap));
    send_byte(w[15:8], $urandom_range(0, maxgap));
    send_byte(w[7:0], $urandom_range(0, maxgap));
`ifdef CFG_CHECKSUM_EN
    send_byte(chk, $urandom_range(0, maxgap));
`else
    if (chk == 8'h00 && maxgap < 0) cyc(1);
`endif
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_ready", 64'(cfg_ready), 64'd1);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_count", 64'(frame_count), 64'd0);
    check("rst_done", 64'(cfg_done), 64'd0);
    check("rst_error", 64'(cfg_error), 64'd0);

    // Single frame
    exp_q.push_back({6'd0, 33'h0_1404_1000});
    send_frame(8'h00, 32'h1404_1000, 8'h00, 0);
    check("t1_wr_en_now", 64'(wr_en), 64'd1);
    cyc(2);
    check("t1_count", 64'(frame_count), 64'd1);
    check("t1_drained", 64'(exp_q.size()), 64'd0);
    check("t1_hold_addr", 64'(wr_addr), 64'd0);
    check("t1_hold_data", 64'(wr_data), 64'h0_1404_1000);

    // Mode bit, random gaps, then END
    do_reset();
    exp_q.push_back({6'd2, 33'h1_1714_0300});
    send_frame(8'h82, 32'h1714_0300, 8'h82, 3);
    send_byte(8'hA5, 2);
    send_byte(8'h3F, 2);
    check("t2_done", 64'(cfg_done), 64'd1);
    check("t2_ready", 64'(cfg_ready), 64'd0);
    poke(8'hA5);
    poke(8'h00);
    cyc(2);
    check("t2_done_sticky", 64'(cfg_done), 64'd1);
    check("t2_count", 64'(frame_count), 64'd1);
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // Bad checksum
    do_reset();
`ifndef CFG_CHECKSUM_EN
    exp_q.push_back({6'd25, 33'h0_0000_0048});
`endif
    send_frame(8'h19, 32'h0000_0048, 8'h00, 0);
`ifdef CFG_CHECKSUM_EN
    check("t3_error", 64'(cfg_error), 64'd1);
    check("t3_ready", 64'(cfg_ready), 64'd0);
    poke(8'hA5);
    poke(8'h00);
    poke(8'h00);
    cyc(2);
    check("t3_error_sticky", 64'(cfg_error), 64'd1);
    check("t3_count", 64'(frame_count), 64'd0);
`else
    cyc(2);
    check("t3_error", 64'(cfg_error), 64'd0);
    check("t3_count", 64'(frame_count), 64'd1);
`endif
    check("t3_drained", 64'(exp_q.size()), 64'd0);

    // Hunting and bad address
    do_reset();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    check("t4_no_err_hunt", 64'(cfg_error), 64'd0);
    check("t4_ready_hunt", 64'(cfg_ready), 64'd1);
    send_byte(8'hA5, 0);
    send_byte(8'h2B, 0);
    check("t4_error", 64'(cfg_error), 64'd1);
    check("t4_ready", 64'(cfg_ready), 64'd0);
    check("t4_done", 64'(cfg_done), 64'd0);

    // Reset mid-frame
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h05, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_reset();
    exp_q.push_back({6'd42, 33'h0_0102_0304});
    send_frame(8'h2A, 32'h0102_0304, 8'h2E, 0);
    cyc(2);
    check("t5_count", 64'(frame_count), 64'd1);
    check("t5_addr", 64'(wr_addr), 64'd42);
    check("t5_drained", 64'(exp_q.size()), 64'd0);

    // Full load of all 43 targets
    do_reset();
    for (int i = 0; i < 43; i++) begin
      logic [7:0]  a;
      logic [31:0] w;
      logic [7:0]  c;
      a = 8'(i) | ((i % 2 == 1) ? 8'h80 : 8'h00);
      w = {8'(i), ~8'(i), 8'(i) ^ 8'h3C, 8'hC3};
      c = a ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      exp_q.push_back({6'(i), a[7], w});
      send_frame(a, w, c, 0);
    end
    send_byte(8'hA5, 0);
    send_byte(8'h3F, 0);
    cyc(2);
    check("t6_count", 64'(frame_count), 64'd43);
    check("t6_done", 64'(cfg_done), 64'd1);
    check("t6_error", 64'(cfg_error), 64'd0);
    check("t6_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpga_cfg_loader.md
# fpga_cfg_loader

Byte-serial configuration loader feeding the `fpga` fabric's configuration storage: LUT memories, the L1 memory, and the B/C/E/D switch `configure` registers. It parses framed configuration records from an upstream byte stream and checks each frame. It issues one addressed 33-bit write per frame, then asserts `cfg_done` to release the fabric for user operation. It replaces hierarchical preloading of configuration words.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker
- `END_ADDR`, 6'h3F, target address that terminates configuration
- `NUM_TARGETS`, 43, number of valid target addresses (0..NUM_TARGETS-1)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `cfg_valid`  in  1  upstream byte valid
- `cfg_data`  in  8  upstream byte
- `cfg_ready`  out  1  loader accepts a byte this cycle
- `wr_en`  out  1  one-cycle write strobe to the fabric config storage
- `wr_addr`  out  6  target address: 0–23 = A1–A24, 24 = L1, 25–32 = B1–B8, 33–40 = C1–C8, 41 = E1, 42 = D1
- `wr_data`  out  33  {mode bit, 32-bit word}; targets narrower than 33 bits take the LSBs
- `frame_count`  out  6  frames written since reset
- `cfg_done`  out  1  configuration complete, sticky
- `cfg_error`  out  1  protocol error, sticky

## Operation
- **Frame format:** SYNC, ADDR, D3, D2, D1, D0, CHK.
  - ADDR[7] is the mode bit (wr_data[32]); ADDR[5:0] is the target; ADDR[6] is ignored.
  - The data word is sent MSB byte first.
  - CHK = ADDR ^ D3 ^ D2 ^ D1 ^ D0.
- A byte transfers on a rising edge with `cfg_valid && cfg_ready`.
- **States:** HUNT, ADDR, DATA, CHK, WRITE, DONE, ERR.
  - HUNT: if the byte == SYNC_BYTE, go to ADDR; otherwise discard the byte and stay.
  - ADDR: if ADDR[5:0] == END_ADDR, go to DONE (no data bytes follow). If ADDR[5:0] >= NUM_TARGETS, go to ERR. Otherwise latch the address and mode bit, clear the byte counter, and go to DATA.
  - DATA: shift in 4 bytes; a 2-bit counter wraps 3→0 on the 4th byte, then go to CHK.
  - CHK: if the byte matches the running XOR, go to WRITE; otherwise go to ERR.
  - WRITE: pulse `wr_en` for one cycle, increment `frame_count` (saturates at 63), return to HUNT.
  - DONE: `cfg_done`=1, `cfg_ready`=0, held until `rst`.
  - ERR: `cfg_error`=1, `cfg_ready`=0, held until `rst`. No `wr_en` is issued for the failing frame.
- `cfg_ready` = 1 in HUNT, ADDR, DATA and CHK; 0 in WRITE, DONE and ERR.
- A SYNC value appearing inside ADDR/DATA/CHK is treated as data; there is no resync mid-frame.
- A target may be written more than once; the last write wins.
- Idle cycles (`cfg_valid`=0) between any bytes are allowed; state and partial word are held.

## Timing
- **Reset values:**
  - state = HUNT
  - `cfg_ready`=1
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0
  - `frame_count`=0
  - `cfg_done`=0, `cfg_error`=0
- Asserting `rst` mid-frame discards the partial frame immediately. No write is issued.
- `wr_en` asserts in the cycle after the CHK byte is accepted. `wr_addr`/`wr_data` are registered and valid in that same cycle, and hold until the next write.
- Minimum frame period: 8 cycles (7 byte cycles + 1 WRITE cycle).
- `cfg_done` rises in the cycle after the END ADDR byte is accepted.
- `cfg_error` rises in the cycle after the offending byte is accepted.

## Configuration
- `CFG_CHECKSUM_EN`:
  - Defined: the CHK byte is present and verified as above.
  - Undefined: frames carry no CHK byte. DATA goes directly to WRITE after the 4th data byte, the minimum frame period is 7 cycles, and checksum errors cannot occur.
  - Address-range errors are detected in both builds.

## Structure
- Package `fpga_cfg_pkg` holds:
  - the state enum
  - SYNC_BYTE, END_ADDR and NUM_TARGETS defaults
  - the target address constants (A_BASE=0, L1_ADDR=24, B_BASE=25, C_BASE=33, E1_ADDR=41, D1_ADDR=42)
  - the 33-bit config word type
- One sub-module, `cfg_frame_asm`: byte counter, word shift register and XOR accumulator. The FSM stays in the top level.

## Test plan
- **Single frame:** stream A5 00 14 04 10 00 00 → one `wr_en` pulse, `wr_addr`=0, `wr_data`=33'h0_1404_1000, `frame_count`=1.
- **Mode bit and gaps:** A5 82 17 14 03 00 82 with random `cfg_valid` gaps, then A5 3F → `wr_addr`=2, `wr_data`=33'h1_1714_0300; `cfg_done`=1 and `cfg_ready`=0 one cycle after the 3F byte.
- **Bad checksum:** A5 19 00 00 00 48 00 (expected CHK 51) → no `wr_en`, `cfg_error`=1, `cfg_ready`=0; subsequent bytes ignored.
- **Bad address and hunting:** garbage bytes 11 22 before A5, then A5 2B → bytes before A5 discarded; 0x2B (43) ≥ NUM_TARGETS, so `cfg_error`=1.
- **Reset mid-frame:** assert `rst` after D2 of an address-5 frame, then send a full frame to address 42 → no address-5 write; one write to 42; `frame_count`=1.
- **Full load:** frames to all 43 targets, then END → 43 `wr_en` pulses in address order, `frame_count`=43, `cfg_done`=1.
  - Repeat with `CFG_CHECKSUM_EN` undefined and 6-byte frames.
